bat_adc_sequencer: RTL
======================

BAT_ADC_SEQUENCER -- requirements
Module: bat_adc_sequencer

Interface
REQ-001 Parameter CONV_PERIOD, default 1000: clock cycles between conversion starts (100 kHz at 100 MHz).
REQ-002 Parameter CONVST_WIDTH, default 4: o_convst high time in cycles.
REQ-003 Parameter EOC_TIMEOUT, default 500: cycles allowed after o_convst falls for both EOCs to assert.
REQ-004 Parameter AVG_LOG2, default 3: log2 of the number of samples averaged per output (8).
REQ-005 Port i_clock, input, 1: single clock; all logic on its rising edge.
REQ-006 Port i_RESET, input, 1: synchronous reset, active-high.
REQ-007 Port i_enable, input, 1: run conversions while high.
REQ-008 Port o_convst, output, 1: shared conversion-start pulse to the Vbat and Ibat ADCs.
REQ-009 Port i_eoc_v, input, 1: Vbat end-of-conversion, active-low, asynchronous.
REQ-010 Port i_eoc_i, input, 1: Ibat end-of-conversion, active-low, asynchronous.
REQ-011 Port i_data_v, input, 8: Vbat ADC data, unsigned, valid while i_eoc_v low.
REQ-012 Port i_data_i, input, 8: Ibat ADC data, unsigned, valid while i_eoc_i low.
REQ-013 Port o_vbat, output, 8: averaged Vbat.
REQ-014 Port o_ibat, output, 8: averaged Ibat.
REQ-015 Port o_valid, output, 1: one-cycle pulse when o_vbat/o_ibat update.
REQ-016 Port o_timeout, output, 1: sticky EOC-timeout flag.

Function
REQ-017 Each EOC input SHALL pass through a 2-flop synchronizer; all EOC decisions use the synchronized value.
REQ-018 States SHALL be IDLE, START, WAIT_EOC, HOLD.
REQ-019 Period counter: counts 0..CONV_PERIOD-1 and wraps while i_enable=1; held at 0 while i_enable=0.
REQ-020 IDLE -> START when i_enable=1 and the period counter equals 0.
REQ-021 START: o_convst=1 for exactly CONVST_WIDTH cycles, then -> WAIT_EOC with o_convst=0.
REQ-022 WAIT_EOC: on the first cycle that channel's synchronized EOC is low, that channel's data SHALL be latched once per conversion; entry into WAIT_EOC clears both captured flags.
REQ-023 WAIT_EOC -> HOLD when both channels are captured; the sample pair is then added to the accumulators in the same transition.
REQ-024 When the timeout counter reaches EOC_TIMEOUT without both captures, -> HOLD, set o_timeout, and discard the partial sample (no accumulation).
REQ-025 HOLD -> START when the period counter wraps to 0 and i_enable=1; otherwise HOLD -> IDLE when i_enable=0.
REQ-026 Accumulators SHALL be 8+AVG_LOG2 bits unsigned with no overflow; sample count SHALL be AVG_LOG2 bits.
REQ-027 On the 2^AVG_LOG2-th accumulated pair: o_vbat/o_ibat = accumulator >> AVG_LOG2 (truncating), o_valid=1 for one cycle on the next clock, and accumulators/count cleared.
REQ-028 The outputs SHALL hold their last values between o_valid pulses.
REQ-029 If i_enable falls in START or WAIT_EOC, o_convst SHALL drop the next cycle, the FSM SHALL go to IDLE, and the partial sample SHALL be discarded. Accumulated samples are retained.
REQ-030 o_timeout SHALL clear only on reset. A timeout and a capture in the same cycle count as a capture.
REQ-031 Parameter constraint: CONV_PERIOD > CONVST_WIDTH + EOC_TIMEOUT + 4.

Reset
REQ-032 On i_RESET=1 at a clock edge, the following SHALL apply: state=IDLE, counters=0, accumulators=0, o_convst=0, o_vbat=0, o_ibat=0, o_valid=0, o_timeout=0.
REQ-033 Reset SHALL take priority over i_enable and EOC in the same cycle.

Verification
REQ-034 Bench: enable with EOCs responding 20 cycles after o_convst falls, data_v=0x80, data_i=0x10 -> o_convst pulses 4 cycles wide every 1000 cycles; after 8 conversions o_valid=1 once, o_vbat=0x80, o_ibat=0x10.
REQ-035 Bench: data_v sequence 0..7 over 8 conversions -> o_vbat=3 (28>>3); data 0xFF x8 -> o_vbat=0xFF, no overflow.
REQ-036 Bench: i_eoc_i never asserts -> o_timeout=1 exactly 500 cycles after o_convst falls; that sample is not counted, conversions continue every 1000 cycles, and o_timeout stays 1.
REQ-037 Bench: drop i_enable 2 cycles into START -> o_convst=0 next cycle, FSM in IDLE, no accumulation; re-enable -> first o_convst when the period counter returns to 0.
REQ-038 Bench: assert i_RESET in WAIT_EOC after 5 accumulated samples -> all outputs 0 next cycle; after re-run, o_valid is first seen only after 8 fresh conversions.
REQ-039 Bench: EOC glitch low for 1 cycle outside WAIT_EOC -> no capture, no state change.

Source files
------------

// File: rtl/bat_adc_sequencer_if.sv
// ADC-side bus of the battery sequencer: shared convert-start plus per-channel EOC and data.
interface bat_adc_sequencer_if;
  logic       o_convst;
  logic       i_eoc_v;
  logic       i_eoc_i;
  logic [7:0] i_data_v;
  logic [7:0] i_data_i;

  modport master (
    output o_convst,
    input  i_eoc_v,
    input  i_eoc_i,
    input  i_data_v,
    input  i_data_i
  );

  modport slave (
    input  o_convst,
    output i_eoc_v,
    output i_eoc_i,
    output i_data_v,
    output i_data_i
  );
endinterface

// File: rtl/bat_adc_sequencer.sv
// Periodic Vbat/Ibat conversion sequencer: shared convert-start, synchronized EOC capture with
// timeout, and averaging of 2**AVG_LOG2 sample pairs into o_vbat/o_ibat.
module bat_adc_sequencer #(
  parameter int CONV_PERIOD  = 1000,
  parameter int CONVST_WIDTH = 4,
  parameter int EOC_TIMEOUT  = 500,
  parameter int AVG_LOG2     = 3
) (
  input  logic                i_clock,
  input  logic                i_RESET,
  input  logic                i_enable,
  bat_adc_sequencer_if.master adc,
  output logic [7:0]          o_vbat,
  output logic [7:0]          o_ibat,
  output logic                o_valid,
  output logic                o_timeout
);

  localparam int PER_W = $clog2(CONV_PERIOD);
  localparam int WID_W = $clog2(CONVST_WIDTH + 1);
  localparam int TO_W  = $clog2(EOC_TIMEOUT + 1);
  localparam int ACC_W = 8 + AVG_LOG2;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CONV_PERIOD - 1);
  localparam logic [WID_W-1:0] WID_LAST = WID_W'(CONVST_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(EOC_TIMEOUT - 1);

  generate
    if (CONV_PERIOD <= CONVST_WIDTH + EOC_TIMEOUT + 4) begin : g_bad_period
      $error("CONV_PERIOD must exceed CONVST_WIDTH + EOC_TIMEOUT + 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, WAIT_EOC, HOLD} state_t;

  state_t              state, state_nxt;
  logic [PER_W-1:0]    period_cnt;
  logic [WID_W-1:0]    width_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [1:0]          eoc_v_sync, eoc_i_sync;
  logic                eoc_v_low, eoc_i_low;
  logic                cap_v, cap_i, cap_v_now, cap_i_now, both_captured;
  logic [7:0]          samp_v, samp_i, samp_v_now, samp_i_now;
  logic [ACC_W-1:0]    acc_v, acc_i, sum_v, sum_i;
  logic [AVG_LOG2-1:0] sample_cnt;
  logic                accumulate, timeout_evt;
  logic                convst_q;

  assign adc.o_convst = convst_q;

  // EOC lines are asynchronous to i_clock; the synchronizers idle high (EOC inactive).
  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      eoc_v_sync <= 2'b11;
      eoc_i_sync <= 2'b11;
    end else begin
      eoc_v_sync <= {eoc_v_sync[0], adc.i_eoc_v};
      eoc_i_sync <= {eoc_i_sync[0], adc.i_eoc_i};
    end
  end

  assign eoc_v_low = ~eoc_v_sync[1];
  assign eoc_i_low = ~eoc_i_sync[1];

  // A channel counts as captured in the same cycle its EOC is first seen low.
  assign cap_v_now     = cap_v | ((state == WAIT_EOC) & eoc_v_low);
  assign cap_i_now     = cap_i | ((state == WAIT_EOC) & eoc_i_low);
  assign samp_v_now    = cap_v ? samp_v : adc.i_data_v;
  assign samp_i_now    = cap_i ? samp_i : adc.i_data_i;
  assign both_captured = cap_v_now & cap_i_now;
  assign sum_v         = acc_v + ACC_W'(samp_v_now);
  assign sum_i         = acc_i + ACC_W'(samp_i_now);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    accumulate  = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE:     if (i_enable && period_cnt == '0) state_nxt = START;
      START:    if (!i_enable)                    state_nxt = IDLE;
                else if (width_cnt == WID_LAST)   state_nxt = WAIT_EOC;
      WAIT_EOC: if (!i_enable) begin
                  state_nxt = IDLE;
                end else if (both_captured) begin
                  state_nxt  = HOLD;
                  accumulate = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                  state_nxt   = HOLD;
                  timeout_evt = 1'b1;
                end
      HOLD:     if (!i_enable)                    state_nxt = IDLE;
                else if (period_cnt == '0)        state_nxt = START;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state      <= IDLE;
      convst_q   <= 1'b0;
      period_cnt <= '0;
      width_cnt  <= '0;
      to_cnt     <= '0;
      cap_v      <= 1'b0;
      cap_i      <= 1'b0;
      samp_v     <= '0;
      samp_i     <= '0;
      acc_v      <= '0;
      acc_i      <= '0;
      sample_cnt <= '0;
      o_vbat     <= '0;
      o_ibat     <= '0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      convst_q   <= (state_nxt == START);
      period_cnt <= (!i_enable || period_cnt == PER_LAST) ? '0 : period_cnt + 1'b1;
      width_cnt  <= (state == START)    ? width_cnt + 1'b1 : '0;
      to_cnt     <= (state == WAIT_EOC) ? to_cnt + 1'b1    : '0;

      // Captured flags live only inside WAIT_EOC, so each conversion starts clean.
      if (state == WAIT_EOC) begin
        cap_v  <= cap_v_now;
        cap_i  <= cap_i_now;
        samp_v <= samp_v_now;
        samp_i <= samp_i_now;
      end else begin
        cap_v  <= 1'b0;
        cap_i  <= 1'b0;
      end

      o_valid   <= 1'b0;
      o_timeout <= o_timeout | timeout_evt;

      if (accumulate) begin
        if (&sample_cnt) begin
          o_vbat     <= sum_v[AVG_LOG2 +: 8];
          o_ibat     <= sum_i[AVG_LOG2 +: 8];
          o_valid    <= 1'b1;
          acc_v      <= '0;
          acc_i      <= '0;
          sample_cnt <= '0;
        end else begin
          acc_v      <= sum_v;
          acc_i      <= sum_i;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

endmodule
